// File: rtl/bcd_pkg.sv
// -----------------------------------------------------------------------------
// bcd_pkg
// Shared types and constants for the sequential binary-to-BCD converter.
//   state_t         : converter FSM states (IDLE, SHIFT)
//   BCD_ADJ_THRESH  : digit value at or above which the +3 adjust applies
//   BCD_ADJ_ADD     : amount added by the adjust step
//   DEF_WIDTH       : default binary input width (also the iteration count)
//   DEF_DIGITS      : default number of BCD digits produced
//   DEF_CNT_W       : iteration counter width for the default input width
// -----------------------------------------------------------------------------
package bcd_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
  localparam logic [3:0] BCD_ADJ_ADD    = 4'd3;

  localparam int DEF_WIDTH  = 32;
  localparam int DEF_DIGITS = 3;
  localparam int DEF_CNT_W  = $clog2(DEF_WIDTH);

endpackage : bcd_pkg

// File: rtl/bcd_digit_adj.sv
// -----------------------------------------------------------------------------
// bcd_digit_adj
// Combinational double-dabble digit correction: a BCD digit of 5 or more gets
// +3 so that the following left shift carries correctly into the next digit.
//   d_i : working BCD digit before the shift
//   d_o : adjusted digit
// -----------------------------------------------------------------------------
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [3:0] d_i,
  output logic [3:0] d_o
);

  // Working digits never exceed 9 before adjustment, so the 4-bit sum
  // cannot wrap.
  assign d_o = (d_i >= BCD_ADJ_THRESH) ? (d_i + BCD_ADJ_ADD) : d_i;

endmodule : bcd_digit_adj

// File: rtl/bin_to_bcd_seq.sv
// -----------------------------------------------------------------------------
// bin_to_bcd_seq
// Sequential binary-to-BCD converter (shift-and-add-3), one input bit per
// clock. Produces the low DIGITS decimal digits of the value plus an overflow
// flag when the value does not fit in DIGITS digits.
//   clk     : system clock, rising edge
//   reset   : asynchronous, active-high
//   data_in : unsigned value, captured on an accepted load
//   load    : conversion request, accepted only while idle
//   ready   : idle and able to accept load
//   busy    : conversion in progress
//   done    : one-cycle pulse, digits/ovf updated on this edge
//   digits  : packed BCD result, [3:0] = units
//   ovf     : last converted value was >= 10^DIGITS
// -----------------------------------------------------------------------------
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int DIGITS = DEF_DIGITS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      data_in,
  input  logic                  load,
  output logic                  ready,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   digits,
  output logic                  ovf
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   shift_q, shift_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic               sticky_q, sticky_d;
  logic [BCD_W-1:0]   digits_q, digits_d;
  logic               ovf_q, ovf_d;
  logic               done_q, done_d;

  logic [BCD_W-1:0]   bcd_adj;
  logic [BCD_W-1:0]   bcd_shifted;
  logic [WIDTH-1:0]   shift_shifted;
  logic               carry_out;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .d_i (bcd_q[4*g +: 4]),
      .d_o (bcd_adj[4*g +: 4])
    );
  end

  // One double-dabble iteration: shift {adjusted BCD, binary} left by one.
  // The bit leaving the top digit is the only evidence that the value does
  // not fit in DIGITS digits.
  assign {carry_out, bcd_shifted, shift_shifted} = {bcd_adj, shift_q, 1'b0};

  // NOTE: every _d is defaulted to its _q before the case so that no path
  // leaves a variable unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    bcd_d    = bcd_q;
    sticky_d = sticky_q;
    digits_d = digits_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (load) begin
          shift_d  = data_in;
          bcd_d    = '0;
          sticky_d = 1'b0;
          cnt_d    = CNT_W'(WIDTH - 1);
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        bcd_d    = bcd_shifted;
        shift_d  = shift_shifted;
        sticky_d = sticky_q | carry_out;
        cnt_d    = cnt_q - CNT_W'(1);
        // Last iteration: publish the result on the same edge.
        if (cnt_q == '0) begin
          cnt_d    = '0;
          digits_d = bcd_shifted;
          ovf_d    = sticky_q | carry_out;
          done_d   = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state updates use non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  // NOTE: the working shift/BCD registers are reset too, not just the
  // control state, so an aborted conversion leaves nothing stale behind.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      shift_q  <= '0;
      bcd_q    <= '0;
      sticky_q <= 1'b0;
      digits_q <= '0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shift_q  <= shift_d;
      bcd_q    <= bcd_d;
      sticky_q <= sticky_d;
      digits_q <= digits_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
    end
  end

  assign ready  = (state_q == IDLE);
  assign busy   = (state_q == SHIFT);
  assign done   = done_q;
  assign digits = digits_q;
  assign ovf    = ovf_q;

endmodule : bin_to_bcd_seq

// File: tb/tb_bin_to_bcd_seq.sv
// -----------------------------------------------------------------------------
// tb_bin_to_bcd_seq
// Scoreboard bench: the stimulus process pushes the expected decimal result
// of every accepted value; a monitor pops and compares on each done pulse.
// -----------------------------------------------------------------------------
module tb_bin_to_bcd_seq;

  localparam int WIDTH  = 32;
  localparam int DIGITS = 3;

  typedef struct {
    logic [11:0] dig;
    logic        ovf;
    int unsigned val;
  } exp_t;

  logic              clk;
  logic              reset;
  logic [WIDTH-1:0]  data_in;
  logic              load;
  logic              ready;
  logic              busy;
  logic              done;
  logic [11:0]       digits;
  logic              ovf;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  logic prev_done = 1'b0;
  exp_t exp_q[$];

  bin_to_bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clk     (clk),
    .reset   (reset),
    .data_in (data_in),
    .load    (load),
    .ready   (ready),
    .busy    (busy),
    .done    (done),
    .digits  (digits),
    .ovf     (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain decimal arithmetic on the value.
  function automatic exp_t model(input int unsigned v);
    exp_t e;
    int unsigned r;
    r       = v % 1000;
    e.dig   = {4'(r / 100), 4'((r / 10) % 10), 4'(r % 10)};
    e.ovf   = (v >= 1000);
    e.val   = v;
    return e;
  endfunction

  // Monitor: compare every completed result against the scoreboard.
  always @(negedge clk) begin
    if (done) begin
      check("done_single_cycle", {63'd0, prev_done}, 64'd0);
      check("ready_at_done", {63'd0, ready}, 64'd1);
      check("busy_at_done", {63'd0, busy}, 64'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_done", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check($sformatf("digits(%0d)", e.val), {52'd0, digits}, {52'd0, e.dig});
        check($sformatf("ovf(%0d)", e.val), {63'd0, ovf}, {63'd0, e.ovf});
      end
    end
    prev_done = done;
  end

  // Pulse load for one cycle; returns once the accepting edge has passed.
  task automatic issue(input int unsigned v, input bit expect_accept);
    @(posedge clk);
    #1;
    load    = 1'b1;
    data_in = v;
    if (expect_accept) exp_q.push_back(model(v));
    @(posedge clk);
    #1;
    load = 1'b0;
  endtask

  // Wait for a done pulse, sampling at negedge; bounded.
  task automatic wait_done(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check("done_timeout", 64'd1, 64'd0);
  endtask

  task automatic convert(input int unsigned v);
    bit seen;
    issue(v, 1'b1);
    wait_done(WIDTH + 8, seen);
  endtask

  initial begin
    bit seen;
    int busy_cnt;
    int t1, t2;

    reset   = 1'b1;
    load    = 1'b0;
    data_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", {63'd0, ready}, 64'd1);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_digits", {52'd0, digits}, 64'd0);
    check("rst_ovf", {63'd0, ovf}, 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // Basic and boundary values.
    convert(255);
    convert(0);
    convert(999);
    convert(1000);

    // All-ones input, also measuring the busy window.
    issue(32'hFFFF_FFFF, 1'b1);
    busy_cnt = 1; // sample after the accepting edge is taken at #1 below
    check("busy_after_accept", {63'd0, busy}, 64'd1);
    seen = 1'b0;
    for (int i = 0; i < WIDTH + 8; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (busy) busy_cnt++;
    end
    if (!seen) check("done_timeout", 64'd1, 64'd0);
    // Sampled at #1 after edge k, then at negedges after edges k .. k+31
    // (the first negedge repeats edge k's window), so subtract that overlap.
    check("busy_cycles", 64'(busy_cnt - 1), 64'(WIDTH));

    // Load while busy is ignored; a load right after done is accepted.
    issue(123, 1'b1);
    repeat (10) @(posedge clk);
    #1;
    load    = 1'b1;
    data_in = 456;
    @(posedge clk);
    #1;
    load = 1'b0;
    wait_done(WIDTH + 8, seen);
    load    = 1'b1;
    data_in = 77;
    exp_q.push_back(model(77));
    @(posedge clk);
    #1;
    load = 1'b0;
    check("accept_after_done", {63'd0, busy}, 64'd1);
    wait_done(WIDTH + 8, seen);

    // Reset in the middle of a conversion.
    issue(789, 1'b0);
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("abort_digits", {52'd0, digits}, 64'd0);
    check("abort_ovf", {63'd0, ovf}, 64'd0);
    check("abort_ready", {63'd0, ready}, 64'd1);
    check("abort_busy", {63'd0, busy}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (WIDTH + 4) @(posedge clk);
    convert(42);

    // Load held high: two back-to-back conversions.
    @(posedge clk);
    #1;
    load    = 1'b1;
    data_in = 7;
    exp_q.push_back(model(7));
    @(posedge clk);
    #1;
    data_in = 88;
    exp_q.push_back(model(88));
    wait_done(WIDTH + 8, seen);
    t1 = cyc;
    wait_done(WIDTH + 8, seen);
    t2 = cyc;
    load = 1'b0;
    check("b2b_spacing", 64'(t2 - t1), 64'(WIDTH + 1));

    // Randomized values, mixing small and full-range inputs.
    for (int i = 0; i < 24; i++) begin
      int unsigned v;
      case (i % 3)
        0:       v = $urandom_range(0, 1100);
        1:       v = $urandom_range(0, 100000);
        default: v = $urandom;
      endcase
      convert(v);
    end

    repeat (4) @(posedge clk);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule : tb_bin_to_bcd_seq
